// File: rtl/mem_lsu_ram.sv
// Data memory for the load/store stage: request/response handshake, byte/half/word access,
// alignment and range checking, and a configurable read latency.
module mem_lsu_ram #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "memory.mem"
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] r_mem [Depth];
  logic [31:0] r_rd_word;
  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic        r_we;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_uns;

  logic                  w_accept;
  logic                  w_err;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load;

  initial begin
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin
      $fatal(1, "mem_lsu_ram: READ_LATENCY must be in 1..4");
    end
    for (int i = 0; i < Depth; i++) r_mem[i] = '0;
  end

  assign o_req_ready = (r_state == StIdle);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_idx       = i_req_addr[ADDR_WIDTH-1:2];
  assign w_lane      = i_req_addr[1:0];

  assign w_err = (i_req_size == 2'd3)
               || (i_req_size == 2'd1 && i_req_addr[0])
               || (i_req_size == 2'd2 && (|i_req_addr[1:0]))
               || (|(i_req_addr >> ADDR_WIDTH));

  // Replicating the store value puts it on every lane; the byte enables pick the right one.
  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = i_req_wdata;
    case (i_req_size)
      2'd0: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{i_req_wdata[7:0]}};
      end
      2'd1: begin
        w_be        = 4'b0011 << w_lane;
        w_wdata_rep = {2{i_req_wdata[15:0]}};
      end
      2'd2:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Storage has no reset; the load word is snapshotted before any later store can alter it.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      if (i_req_we && !w_err) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
      r_rd_word <= r_mem[w_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'd0;
      r_lane  <= 2'd0;
      r_uns   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we   <= i_req_we;
        r_err  <= w_err;
        r_size <= i_req_size;
        r_lane <= w_lane;
        r_uns  <= i_req_unsigned;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          if (READ_LATENCY == 1) begin
            w_state_nxt = StResp;
          end else begin
            w_cnt_nxt   = 2'(READ_LATENCY - 1);
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_nxt = StResp;
      end
      StResp: begin
        if (i_rsp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_shifted = r_rd_word >> {r_lane, 3'b000};

  always_comb begin
    w_load = 32'd0;
    case (r_size)
      2'd0: w_load = r_uns ? {24'd0, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_load = r_uns ? {16'd0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      2'd2: w_load = w_shifted;
      default: w_load = 32'd0;
    endcase
  end

  assign o_rsp_valid = (r_state == StResp);
  assign o_rsp_err   = o_rsp_valid && r_err;
  assign o_rsp_rdata = (o_rsp_valid && !r_err && !r_we) ? w_load : 32'd0;

endmodule

// File: tb/tb_mem_lsu_ram.sv
// Bench for mem_lsu_ram: three instances (read latency 1, 2, 3) checked every cycle against a
// byte-addressed memory model, plus directed literal expectations.
module tb_mem_lsu_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we [3];
  logic [31:0] req_addr [3];
  logic [1:0]  req_size [3];
  logic        req_unsigned [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model state: byte memory per instance and the single outstanding expected response.
  logic [7:0]  mm [3][16384];
  logic        pend [3];
  logic [31:0] e_rdata [3];
  logic        e_err [3];
  int          e_t [3];
  logic        seen [3];
  int          lat [3];
  logic [31:0] last_rdata [3];
  logic        last_err [3];
  int          rsp_cnt [3];
  logic        mon_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_lsu_ram #(
      .ADDR_WIDTH  (14),
      .READ_LATENCY(g + 1),
      .INIT_FILE   ("")
    ) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req_valid   (req_valid[g]),
      .o_req_ready   (req_ready[g]),
      .i_req_we      (req_we[g]),
      .i_req_addr    (req_addr[g]),
      .i_req_size    (req_size[g]),
      .i_req_unsigned(req_unsigned[g]),
      .i_req_wdata   (req_wdata[g]),
      .o_rsp_valid   (rsp_valid[g]),
      .i_rsp_ready   (rsp_ready[g]),
      .o_rsp_rdata   (rsp_rdata[g]),
      .o_rsp_err     (rsp_err[g])
    );
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input int k, input logic we, input logic [31:0] a,
                              input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                              input int t);
    logic        err;
    logic [31:0] v;
    int          ai;
    err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
       || (a >= 32'h4000);
    ai = int'(a[13:0]);
    v  = 32'd0;
    if (!err && we) begin
      mm[k][ai] = wd[7:0];
      if (sz >= 2'd1) mm[k][ai+1] = wd[15:8];
      if (sz == 2'd2) begin
        mm[k][ai+2] = wd[23:16];
        mm[k][ai+3] = wd[31:24];
      end
    end else if (!err) begin
      if (sz == 2'd0) v = uns ? 32'(mm[k][ai]) : 32'(signed'(mm[k][ai]));
      else if (sz == 2'd1) v = uns ? 32'({mm[k][ai+1], mm[k][ai]})
                                   : 32'(signed'({mm[k][ai+1], mm[k][ai]}));
      else v = {mm[k][ai+3], mm[k][ai+2], mm[k][ai+1], mm[k][ai]};
    end
    pend[k]    = 1'b1;
    seen[k]    = 1'b0;
    e_t[k]     = t;
    e_err[k]   = err;
    e_rdata[k] = v;
  endtask

  // Called at posedge+1; returns the cycle of the accepting edge.
  task automatic issue(input int k, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, output int t);
    req_valid[k]    = 1'b1;
    req_we[k]       = we;
    req_addr[k]     = a;
    req_size[k]     = sz;
    req_unsigned[k] = uns;
    req_wdata[k]    = wd;
    t = -1;
    for (int n = 0; n < 40 && t < 0; n++) begin
      if (req_ready[k]) begin
        @(posedge clk);
        #1;
        t = cyc;
        model_accept(k, we, a, sz, uns, wd, t);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    req_valid[k] = 1'b0;
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: got no acceptance expected one", k);
    end
  endtask

  task automatic wait_resp(input int k);
    for (int n = 0; n < 60 && pend[k]; n++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (pend[k]) begin
      bad++;
      $display("FAIL resp_timeout dut%0d: got pending expected handshake", k);
    end
  endtask

  task automatic do_req(input int k, input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic [31:0] x_rdata,
                        input logic x_err, input string name);
    int t;
    issue(k, we, a, sz, uns, wd, t);
    wait_resp(k);
    check({name, "_rdata"}, k, last_rdata[k], x_rdata);
    check({name, "_err"}, k, 32'(last_err[k]), 32'(x_err));
  endtask

  // Compare process: every cycle, valid/ready/data against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mon_v = pend[k] && (cyc >= e_t[k] + k);
        check("rsp_valid", k, 32'(rsp_valid[k]), 32'(mon_v));
        check("req_ready", k, 32'(req_ready[k]), 32'(!pend[k]));
        if (rsp_valid[k] && mon_v) begin
          check("rsp_rdata", k, rsp_rdata[k], e_rdata[k]);
          check("rsp_err", k, 32'(rsp_err[k]), 32'(e_err[k]));
          if (!seen[k]) begin
            seen[k] = 1'b1;
            lat[k]  = cyc - e_t[k] + 1;
          end
          if (rsp_ready[k]) begin
            pend[k]       = 1'b0;
            last_rdata[k] = rsp_rdata[k];
            last_err[k]   = rsp_err[k];
            rsp_cnt[k]++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, c0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16384; i++) mm[k][i] = 8'h00;
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_size[k] = '0;
      req_unsigned[k] = 1'b0; req_wdata[k] = '0; rsp_ready[k] = 1'b1;
      pend[k] = 1'b0; seen[k] = 1'b0; e_t[k] = 0; lat[k] = 0; rsp_cnt[k] = 0;
      e_rdata[k] = '0; e_err[k] = 1'b0; last_rdata[k] = '0; last_err[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_req_ready", k, 32'(req_ready[k]), 32'd1);
      check("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      check("reset_rsp_rdata", k, rsp_rdata[k], 32'd0);
      check("reset_rsp_err", k, 32'(rsp_err[k]), 32'd0);
    end

    // Word store/load, latency 1
    do_req(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, "st_word");
    check("lat_rl1", 0, 32'(lat[0]), 32'd1);
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "ld_word");

    // Byte lane and extension
    do_req(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 32'h0, 1'b0, "st_byte");
    do_req(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, "ld_byte_s");
    do_req(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0, "ld_byte_u");
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b1, 32'h0, 32'h80ADBEEF, 1'b0, "ld_word2");
    do_req(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 32'hFFFF80AD, 1'b0, "ld_half_s");
    do_req(0, 1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 32'h000080AD, 1'b0, "ld_half_u");
    do_req(0, 1'b1, 32'h10, 2'd1, 1'b0, 32'hAAAA1234, 32'h0, 1'b0, "st_half");
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h80AD1234, 1'b0, "ld_word3");

    // Error cases
    do_req(0, 1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, "err_half_mis");
    do_req(0, 1'b1, 32'h12, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b1, "err_word_mis");
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h80AD1234, 1'b0, "ld_unchanged");
    do_req(0, 1'b0, 32'h4000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, "err_range");
    do_req(0, 1'b1, 32'h4010, 2'd0, 1'b0, 32'h55, 32'h0, 1'b1, "err_range_st");
    do_req(0, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, "err_size3");
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h80AD1234, 1'b0, "ld_no_alias");

    // Latency 3 with back-pressure
    do_req(2, 1'b1, 32'h8, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, "st_rl3");
    rsp_ready[2] = 1'b0;
    issue(2, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, t0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      check("hold_req_ready", 2, 32'(req_ready[2]), 32'd0);
    end
    check("lat_rl3", 2, 32'(lat[2]), 32'd3);
    check("hold_rsp_valid", 2, 32'(rsp_valid[2]), 32'd1);
    check("hold_rsp_rdata", 2, rsp_rdata[2], 32'hCAFEF00D);
    rsp_ready[2] = 1'b1;
    wait_resp(2);
    check("rl3_rdata", 2, last_rdata[2], 32'hCAFEF00D);

    // Reset during WAIT
    c0 = rsp_cnt[2];
    issue(2, 1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678, t0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) pend[k] = 1'b0;
    #1;
    check("rst_mid_valid", 2, 32'(rsp_valid[2]), 32'd0);
    check("rst_mid_ready", 2, 32'(req_ready[2]), 32'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_resp", 2, 32'(rsp_cnt[2]), 32'(c0));
    do_req(2, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0, "ld_after_rst");

    // Back-to-back, latency 2
    do_req(1, 1'b1, 32'h4, 2'd2, 1'b0, 32'h0BADCAFE, 32'h0, 1'b0, "st_rl2");
    check("lat_rl2", 1, 32'(lat[1]), 32'd2);
    c0 = rsp_cnt[1];
    issue(1, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, t0);
    issue(1, 1'b0, 32'h5, 2'd0, 1'b1, 32'h0, t1);
    issue(1, 1'b0, 32'h6, 2'd1, 1'b0, 32'h0, t2);
    issue(1, 1'b0, 32'h7, 2'd0, 1'b0, 32'h0, t3);
    wait_resp(1);
    check("b2b_gap1", 1, 32'(t1 - t0), 32'd3);
    check("b2b_gap2", 1, 32'(t2 - t1), 32'd3);
    check("b2b_gap3", 1, 32'(t3 - t2), 32'd3);
    check("b2b_count", 1, 32'(rsp_cnt[1] - c0), 32'd4);
    check("b2b_last", 1, last_rdata[1], 32'h0000000B);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
